// File: rtl/mux_nx1_skid.sv
// ----------------------------------------------------------------------------
// mux_nx1_skid
//
// Purpose:
//   Parametrised N:1 select mux with a registered, flow-controlled output
//   stage. The selected word (plus an out-of-range error flag) is captured
//   into a 2-entry skid buffer. A stalled consumer therefore never causes a
//   selected word to be dropped. There is no combinational path from the
//   input side to out_*. in_ready depends only on the buffer state.
//
// Parameters:
//   WIDTH   data width of each input and of the output (default 32)
//   NUM_IN  number of inputs, legal range 2..16 (default 3)
//   SEL_W   derived select width, $clog2(NUM_IN); not user-settable
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_data    in   packed inputs; input k is in_data[k*WIDTH +: WIDTH]
//   sel        in   input index, sampled with in_data
//   in_valid   in   upstream offers a word and a select
//   in_ready   out  buffer can accept a word (low only when both entries full)
//   out_data   out  head word of the buffer
//   out_err    out  head word came from an out-of-range select
//   out_valid  out  head word is valid
//   out_ready  in   downstream takes the head word
//   err_clr    in   (MUX_ERR_CNT_EN only) synchronous clear of err_cnt
//   err_cnt    out  (MUX_ERR_CNT_EN only) saturating count of accepted
//                   out-of-range selects
//
// Optional feature macro: MUX_ERR_CNT_EN
// ----------------------------------------------------------------------------
module mux_nx1_skid #(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 3,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef MUX_ERR_CNT_EN
    ,
    input  logic                    err_clr,
    output logic [7:0]              err_cnt
`endif
);

    // Buffer occupancy, decoded from the two valid bits.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    logic             r_mainValid;
    logic [WIDTH-1:0] r_mainData;
    logic             r_mainErr;
    logic             r_skidValid;
    logic [WIDTH-1:0] r_skidData;
    logic             r_skidErr;

    logic             w_mainValidNext;
    logic [WIDTH-1:0] w_mainDataNext;
    logic             w_mainErrNext;
    logic             w_skidValidNext;
    logic [WIDTH-1:0] w_skidDataNext;
    logic             w_skidErrNext;

    logic [WIDTH-1:0] w_capData;
    logic             w_capErr;
    logic             w_accept;
    logic             w_pop;
    state_t           w_state;

    // The select is compared against every legal index rather than used as a
    // part-select offset, so an out-of-range select never reads past the end
    // of in_data. An out-of-range select yields a zero word with the error
    // flag set.
    always_comb begin
        w_capData = '0;
        w_capErr  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                w_capData = in_data[k*WIDTH +: WIDTH];
                w_capErr  = 1'b0;
            end
        end
    end

    assign in_ready  = !r_skidValid;
    assign w_accept  = in_valid && in_ready;
    assign w_pop     = r_mainValid && out_ready;

    assign out_data  = r_mainData;
    assign out_err   = r_mainErr;
    assign out_valid = r_mainValid;

    always_comb begin
        if (r_skidValid) begin
            w_state = ST_FULL;
        end else if (r_mainValid) begin
            w_state = ST_ONE;
        end else begin
            w_state = ST_EMPTY;
        end
    end

    // Next-state logic for the two entries. Every register defaults to
    // holding its value, so out_data and out_err keep the last word while
    // the buffer is empty.
    always_comb begin
        w_mainValidNext = r_mainValid;
        w_mainDataNext  = r_mainData;
        w_mainErrNext   = r_mainErr;
        w_skidValidNext = r_skidValid;
        w_skidDataNext  = r_skidData;
        w_skidErrNext   = r_skidErr;

        case (w_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_mainValidNext = 1'b1;
                    w_mainDataNext  = w_capData;
                    w_mainErrNext   = w_capErr;
                end
            end
            ST_ONE: begin
                if (w_accept && w_pop) begin
                    w_mainDataNext  = w_capData;
                    w_mainErrNext   = w_capErr;
                end else if (w_accept) begin
                    w_skidValidNext = 1'b1;
                    w_skidDataNext  = w_capData;
                    w_skidErrNext   = w_capErr;
                end else if (w_pop) begin
                    w_mainValidNext = 1'b0;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a pop can happen.
                if (w_pop) begin
                    w_mainDataNext  = r_skidData;
                    w_mainErrNext   = r_skidErr;
                    w_skidValidNext = 1'b0;
                end
            end
            default: begin
                w_mainValidNext = 1'b0;
                w_skidValidNext = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mainValid <= 1'b0;
            r_mainData  <= '0;
            r_mainErr   <= 1'b0;
            r_skidValid <= 1'b0;
            r_skidData  <= '0;
            r_skidErr   <= 1'b0;
        end else begin
            r_mainValid <= w_mainValidNext;
            r_mainData  <= w_mainDataNext;
            r_mainErr   <= w_mainErrNext;
            r_skidValid <= w_skidValidNext;
            r_skidData  <= w_skidDataNext;
            r_skidErr   <= w_skidErrNext;
        end
    end

`ifdef MUX_ERR_CNT_EN
    logic [7:0] r_errCnt;

    // Counts accepted words with an out-of-range select and saturates at 255.
    // A clear on the same edge as a counted error wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_errCnt <= 8'd0;
        end else if (err_clr) begin
            r_errCnt <= 8'd0;
        end else if (w_accept && w_capErr && (r_errCnt != 8'hFF)) begin
            r_errCnt <= r_errCnt + 8'd1;
        end
    end

    assign err_cnt = r_errCnt;
`endif

endmodule
